// File: rtl/matrix_load_buffer.sv
// Serial size/element loader feeding the parallel matrix multiplier: builds zero-padded
// row-major A/B buses and holds them with mat_valid until mat_ack. Define
// MATLOAD_B_COLMAJOR_EN to accept the B stream in column-major order.
module matrix_load_buffer #(
  parameter int MAX_SIZE   = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   cfg_valid,
  input  logic [31:0]                            cfg_size,
  output logic                                   cfg_ready,
  output logic                                   cfg_err,
  input  logic                                   in_valid,
  input  logic [DATA_WIDTH-1:0]                  in_data,
  output logic                                   in_ready,
  output logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0] mat_a,
  output logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0] mat_b,
  output logic [31:0]                            matrix_size,
  output logic                                   mat_valid,
  input  logic                                   mat_ack
);

  localparam int NELEM = MAX_SIZE * MAX_SIZE;
  localparam int CW    = $clog2(MAX_SIZE + 1);
  localparam int IW    = $clog2(NELEM + 1);

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, HOLD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   row_q, row_d, col_q, col_d;
  logic [31:0]     size_q, size_d;
  logic            cfg_err_q, cfg_err_d;
  logic            clr_buses, we_a, we_b;
  logic            size_ok, row_last, col_last;
  logic [CW-1:0]   last_idx;
  logic [IW-1:0]   wr_idx;

  assign size_ok  = (cfg_size != 32'd0) && (cfg_size <= 32'(MAX_SIZE));
  assign last_idx = CW'(size_q - 32'd1);
  assign row_last = (row_q == last_idx);
  assign col_last = (col_q == last_idx);
  assign wr_idx   = IW'(row_q) * IW'(MAX_SIZE) + IW'(col_q);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    size_d    = size_q;
    cfg_err_d = 1'b0;
    clr_buses = 1'b0;
    we_a      = 1'b0;
    we_b      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (size_ok) begin
            size_d    = cfg_size;
            clr_buses = 1'b1;
            row_d     = '0;
            col_d     = '0;
            state_d   = LOAD_A;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      LOAD_A: begin
        if (in_valid) begin
          we_a = 1'b1;
          if (col_last) begin
            col_d = '0;
            if (row_last) begin
              row_d   = '0;
              state_d = LOAD_B;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      LOAD_B: begin
        if (in_valid) begin
          we_b = 1'b1;
`ifdef MATLOAD_B_COLMAJOR_EN
          // Column-major B: row is the fast counter.
          if (row_last) begin
            row_d = '0;
            if (col_last) begin
              col_d   = '0;
              state_d = HOLD;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
`else
          if (col_last) begin
            col_d = '0;
            if (row_last) begin
              row_d   = '0;
              state_d = HOLD;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
`endif
        end
      end
      HOLD: begin
        if (mat_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      size_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      size_q    <= size_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // One register pair per element; untouched elements stay zero after the clear.
  for (genvar gi = 0; gi < NELEM; gi++) begin : g_elem
    logic [DATA_WIDTH-1:0] a_q, b_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q <= '0;
        b_q <= '0;
      end else if (clr_buses) begin
        a_q <= '0;
        b_q <= '0;
      end else if (wr_idx == IW'(gi)) begin
        if (we_a) a_q <= in_data;
        if (we_b) b_q <= in_data;
      end
    end
    assign mat_a[gi*DATA_WIDTH +: DATA_WIDTH] = a_q;
    assign mat_b[gi*DATA_WIDTH +: DATA_WIDTH] = b_q;
  end

  assign cfg_ready   = (state_q == IDLE);
  assign in_ready    = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign mat_valid   = (state_q == HOLD);
  assign cfg_err     = cfg_err_q;
  assign matrix_size = size_q;

endmodule

// File: tb/tb_matrix_load_buffer.sv
// Randomized bench for matrix_load_buffer against an array-based model of the
// expected A/B matrices (honours MATLOAD_B_COLMAJOR_EN for the B placement).
module tb_matrix_load_buffer;
  localparam int MS = 10;
  localparam int DW = 32;
  localparam int NE = MS * MS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [31:0]   cfg_size = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          mat_ack = 1'b0;
  logic          cfg_ready, cfg_err, in_ready, mat_valid;
  logic [NE*DW-1:0] mat_a, mat_b;
  logic [31:0]   matrix_size;

  int n_checks = 0;
  int n_errors = 0;
  int xfers    = 0;
  int exp_size = 0;
  logic [DW-1:0] exp_a [NE];
  logic [DW-1:0] exp_b [NE];
  logic [DW-1:0] a_src [NE];
  logic [DW-1:0] b_src [NE];

  always #5 clk = ~clk;

  matrix_load_buffer #(.MAX_SIZE(MS), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_size(cfg_size), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mat_a(mat_a), .mat_b(mat_b), .matrix_size(matrix_size),
    .mat_valid(mat_valid), .mat_ack(mat_ack)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int e = 0; e < NE; e++) begin
      exp_a[e] = '0;
      exp_b[e] = '0;
    end
  endtask

  task automatic check_buses(input string tag);
    for (int e = 0; e < NE; e++) begin
      check($sformatf("%s mat_a[%0d]", tag, e), 64'(mat_a[e*DW +: DW]), 64'(exp_a[e]));
      check($sformatf("%s mat_b[%0d]", tag, e), 64'(mat_b[e*DW +: DW]), 64'(exp_b[e]));
    end
    check({tag, " matrix_size"}, 64'(matrix_size), 64'(exp_size));
  endtask

  task automatic send_cfg(input int sz);
    bit ok;
    ok = (sz >= 1) && (sz <= MS);
    check("cfg_ready_idle", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_size  = 32'(sz);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    check($sformatf("cfg_err size=%0d", sz), cfg_err, !ok);
    if (ok) begin
      clear_model();
      exp_size = sz;
      xfers    = 0;
    end
    check("matrix_size_after_cfg", 64'(matrix_size), 64'(exp_size));
    check("in_ready_after_cfg", in_ready, ok);
    if (!ok) begin
      @(posedge clk); #1;
      check("cfg_err_one_cycle", cfg_err, 0);
      check("cfg_ready_after_err", cfg_ready, 1);
    end
  endtask

  // toggle=1: exactly one idle cycle before each beat; otherwise random stalls and stray acks.
  task automatic push_beat(input logic [DW-1:0] d, input bit toggle);
    bit rdy;
    if (toggle) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end else if ($urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    if (!toggle) mat_ack = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    in_data  = d;
    rdy = in_ready;
    check("in_ready_load", rdy, 1);
    @(posedge clk); #1;
    if (rdy) xfers++;
    in_valid = 1'b0;
    mat_ack  = 1'b0;
  endtask

  task automatic load(input int sz, input bit toggle);
    int total, r, c;
    total = sz * sz;
    send_cfg(sz);
    for (int n = 0; n < total; n++) begin
      push_beat(a_src[n], toggle);
      exp_a[(n / sz) * MS + (n % sz)] = a_src[n];
    end
    check("mat_valid_after_a", mat_valid, 0);
    for (int n = 0; n < total; n++) begin
      if (n == total - 1) check("mat_valid_before_last_b", mat_valid, 0);
      push_beat(b_src[n], toggle);
`ifdef MATLOAD_B_COLMAJOR_EN
      r = n % sz;
      c = n / sz;
`else
      r = n / sz;
      c = n % sz;
`endif
      exp_b[r * MS + c] = b_src[n];
    end
    check($sformatf("mat_valid_after_load sz=%0d", sz), mat_valid, 1);
    check("in_ready_hold", in_ready, 0);
    check("cfg_ready_hold", cfg_ready, 0);
    check($sformatf("xfer_count sz=%0d", sz), 64'(xfers), 64'(2 * total));
    check_buses($sformatf("load%0d", sz));
    $display("load size=%0d toggle=%0d transfers=%0d", sz, toggle, xfers);
  endtask

  task automatic hold_test(input int cycles);
    in_valid  = 1'b1;
    cfg_valid = 1'b1;
    cfg_size  = 32'd2;
    for (int i = 0; i < cycles; i++) begin
      in_data = $urandom;
      @(posedge clk); #1;
      check("hold_mat_valid", mat_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_cfg_ready", cfg_ready, 0);
    end
    in_valid  = 1'b0;
    cfg_valid = 1'b0;
    check_buses("hold");
  endtask

  task automatic ack();
    check("mat_valid_pre_ack", mat_valid, 1);
    mat_ack = 1'b1;
    @(posedge clk); #1;
    mat_ack = 1'b0;
    check("mat_valid_post_ack", mat_valid, 0);
    check("cfg_ready_post_ack", cfg_ready, 1);
    check("in_ready_post_ack", in_ready, 0);
    $display("ack size=%0d", exp_size);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " cfg_ready"}, cfg_ready, 1);
    check({tag, " in_ready"}, in_ready, 0);
    check({tag, " mat_valid"}, mat_valid, 0);
    check({tag, " cfg_err"}, cfg_err, 0);
    check({tag, " matrix_size"}, 64'(matrix_size), 0);
    check({tag, " mat_a_zero"}, |mat_a, 0);
    check({tag, " mat_b_zero"}, |mat_b, 0);
  endtask

  initial begin
    clear_model();
    #12;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of LOAD_A.
    for (int n = 0; n < NE; n++) a_src[n] = $urandom | 32'd1;
    send_cfg(3);
    for (int n = 0; n < 3; n++) push_beat(a_src[n], 1'b0);
    check("partial_xfers", 64'(xfers), 3);
    rst_n = 1'b0;
    #1;
    clear_model();
    exp_size = 0;
    check_reset_outputs("midload_reset");
    $display("reset asserted after 3 A beats");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed size-2 load.
    for (int n = 0; n < 4; n++) begin
      a_src[n] = 32'(n + 1);
      b_src[n] = 32'(n + 5);
    end
    load(2, 1'b0);
    ack();

    // Out-of-range sizes leave everything untouched.
    send_cfg(0);
    send_cfg(11);
    check_buses("after_bad_cfg");

    // Full-size load with in_valid toggling, then a long hold.
    for (int n = 0; n < NE; n++) begin
      a_src[n] = $urandom;
      b_src[n] = $urandom;
    end
    load(MS, 1'b1);
    hold_test(20);
    ack();

    // Size 3 followed by size 1: larger data must be cleared.
    for (int n = 0; n < 9; n++) begin
      a_src[n] = $urandom | 32'd1;
      b_src[n] = $urandom | 32'd1;
    end
    load(3, 1'b0);
    ack();
    a_src[0] = 32'd7;
    b_src[0] = 32'd9;
    load(1, 1'b0);
    ack();

    // Random sizes and stall patterns.
    for (int it = 0; it < 6; it++) begin
      int sz;
      sz = $urandom_range(1, MS);
      for (int n = 0; n < NE; n++) begin
        a_src[n] = $urandom;
        b_src[n] = $urandom;
      end
      load(sz, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) hold_test($urandom_range(1, 5));
      ack();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/matrix_load_buffer.md
Name: matrix_load_buffer

Overview:
- Upstream feeder for the combinational parallel matrix multiplier.
- Receives matrix size plus A and B elements as a serial valid/ready stream.
- Assembles them into the flattened, zero-padded row-major buses the multiplier consumes.
- Holds the buses stable, with mat_valid high, until the downstream stage acknowledges.

Parameters:
- MAX_SIZE, 10, maximum matrix dimension; also the flattened row stride.
- DATA_WIDTH, 32, width of one element.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  size command valid.
- cfg_size  in  32  requested matrix size.
- cfg_ready  out  1  high only in IDLE.
- cfg_err  out  1  one-cycle pulse when an out-of-range size is accepted.
- in_valid  in  1  element valid.
- in_data  in  DATA_WIDTH  element value.
- in_ready  out  1  high only in LOAD_A and LOAD_B.
- mat_a  out  MAX_SIZE*MAX_SIZE*DATA_WIDTH  flattened A; element (r,c) at bit offset (r*MAX_SIZE+c)*DATA_WIDTH.
- mat_b  out  MAX_SIZE*MAX_SIZE*DATA_WIDTH  flattened B; same layout as mat_a.
- matrix_size  out  32  latched size for the multiplier.
- mat_valid  out  1  buses complete and stable.
- mat_ack  in  1  downstream consumed the buses.

Behaviour:
- Reset (async assert, sync release): state=IDLE; mat_a=0, mat_b=0, matrix_size=0, mat_valid=0, cfg_err=0, in_ready=0, cfg_ready=1; row/col counters cleared.
- A transfer occurs only on valid&&ready sampled at the rising edge.
- IDLE, cfg transfer, size in range (1..MAX_SIZE): latch matrix_size; clear mat_a and mat_b to 0 in the same edge; row=col=0; go to LOAD_A.
- IDLE, cfg transfer, size out of range (0 or >MAX_SIZE): cfg_err=1 for one cycle; stay IDLE; matrix_size and buses unchanged.
- LOAD_A, per element transfer:
  - write in_data to mat_a(row,col).
  - col increments; when col=size-1, col wraps to 0 and row increments.
  - on element (size-1,size-1): row=col=0, go to LOAD_B.
- LOAD_B: identical counting into mat_b. On the last element go to HOLD; mat_valid=1 on the cycle after the last B transfer (1-cycle latency).
- HOLD: mat_valid=1; mat_a, mat_b and matrix_size frozen; in_ready=0; cfg_ready=0. On mat_ack=1, mat_valid=0 next cycle and go to IDLE. Buses keep their contents until the next in-range cfg clears them.
- mat_ack outside HOLD is ignored. in_valid in IDLE or HOLD is ignored (no transfer, no state change).
- Elements outside the size×size region always read 0, so the multiplier's padding is exact.
- Size 1: one A beat, one B beat, then HOLD.
- Size MAX_SIZE: MAX_SIZE² beats each; counters must not exceed MAX_SIZE-1.
- Reset mid-load (any state): immediately returns all outputs to reset values. Partial data is discarded; no mat_valid.
- in_valid may drop between beats; counters advance only on transfers. Stalls of any length are legal.

Optional Feature:
- Macro MATLOAD_B_COLMAJOR_EN.
- Defined: the B stream is column-major. The row counter advances fastest in LOAD_B: element n is written to (n mod size, n div size). A loading is unchanged. Output bus layout is unchanged (still row-major).
- Undefined: B is row-major, identical to A.

Test Plan:
- Reset during LOAD_A after 3 beats → all outputs zero, cfg_ready=1, in_ready=0. A fresh size-2 load then completes normally.
- cfg_size=2; A stream 1,2,3,4; B stream 5,6,7,8 →
  - mat_valid rises the cycle after the 8th beat.
  - mat_a offsets 0,1,10,11 = 1,2,3,4; mat_b offsets 0,1,10,11 = 5,6,7,8; all other elements 0.
  - With MATLOAD_B_COLMAJOR_EN, mat_b offsets 0,10,1,11 = 5,6,7,8.
- cfg_size=0, then cfg_size=11 → cfg_err pulses once each; state stays IDLE; matrix_size unchanged.
- cfg_size=10, 200 beats with in_valid toggling every other cycle → exactly 200 transfers. Last A element (9,9) and last B element (9,9) are correct; mat_valid then asserts.
- In HOLD, hold mat_ack=0 for 20 cycles while driving in_valid=1 and cfg_valid=1 → buses unchanged, no transfers. Then mat_ack=1 → mat_valid=0 next cycle and cfg_ready=1.
- After a size-3 load and ack, issue cfg_size=1 with A=7, B=9 → mat_a offset 0=7, mat_b offset 0=9, all previous size-3 data cleared to 0.
